// File: rtl/spi_cmd_master_pkg.sv
// Shared SPI command-protocol package: command codes, master FSM states,
// frame constants and command-classification helpers.
`ifndef SPI_WORD_LENGTH
`define SPI_WORD_LENGTH 8
`endif

package spi_cmd_master_pkg;

  localparam int         SPI_WORD_W      = `SPI_WORD_LENGTH;
  localparam int         SPI_FRAME_WORDS = 3;
  localparam logic [7:0] SPI_DUMMY_BYTE  = 8'h00;

  // Bit 7 set marks a write command; the low bits select the target register group.
  typedef enum logic [7:0] {
    CMD_RD_STATUS = 8'h01,
    CMD_RD_FB     = 8'h02,
    CMD_RD_DIAG   = 8'h03,
    CMD_RD_ID     = 8'h04,
    CMD_WR_CTRL   = 8'h81,
    CMD_WR_CONT   = 8'h82,
    CMD_WR_CLR    = 8'h83,
    CMD_WR_CFG    = 8'h84
  } spi_cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    DONE,
    GAP
  } spi_master_state_t;

  function automatic logic is_write_cmd(input logic [7:0] cmd);
    return cmd[7];
  endfunction

  function automatic logic is_valid_cmd(input logic [7:0] cmd);
    case (cmd)
      CMD_RD_STATUS, CMD_RD_FB, CMD_RD_DIAG, CMD_RD_ID,
      CMD_WR_CTRL, CMD_WR_CONT, CMD_WR_CLR, CMD_WR_CFG: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/spi_sclk_div.sv
// SCLK half-period tick generator: o_tick pulses every CLK_DIV enabled cycles,
// restarting from zero whenever i_clr is asserted at frame start.
module spi_sclk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int                CNT_W = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (i_clr || o_tick)
      r_cnt <= '0;
    else if (i_en)
      r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/spi_cmd_master.sv
// Host-side SPI mode-0 initiator: one request becomes a three-word cs_n-framed
// transaction; the third MISO word is returned. SPI_CMD_CHECK_EN rejects unknown commands.
module spi_cmd_master
  import spi_cmd_master_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 8,
  parameter int WORD_W  = SPI_WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [WORD_W-1:0] req_cmd,
  input  logic [WORD_W-1:0] req_index,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic              spi_sclk,
  output logic              spi_cs_n,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int               NBITS    = SPI_FRAME_WORDS * WORD_W;
  localparam int               BIT_W    = $clog2(NBITS + 1);
  localparam int               GAP_W    = $clog2(CS_GAP + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(NBITS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((CS_GAP > 1) ? CS_GAP - 2 : 0);
  localparam logic             HAS_GAP  = (CS_GAP > 1);

  spi_master_state_t r_state, w_state_next;
  logic              r_sclk_hi;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [NBITS-1:0]  r_tx;
  logic [WORD_W-1:0] r_rx;
  logic [WORD_W-1:0] r_rsp_data;
  logic              r_err;
  logic              w_accept, w_tick, w_cmd_ok, w_last_bit, w_div_en;

  assign w_accept   = req_valid && (r_state == IDLE);
  assign w_last_bit = (r_bit_cnt == LAST_BIT);
  assign w_div_en   = (r_state == SETUP) || (r_state == SHIFT);

`ifdef SPI_CMD_CHECK_EN
  assign w_cmd_ok = is_valid_cmd(req_cmd);
`else
  assign w_cmd_ok = 1'b1;
`endif

  spi_sclk_div #(.CLK_DIV(CLK_DIV)) u_sclk_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_accept),
    .i_en   (w_div_en),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = w_cmd_ok ? SETUP : DONE;
      SETUP:   if (w_tick) w_state_next = SHIFT;
      SHIFT:   if (w_tick && !r_sclk_hi && w_last_bit) w_state_next = DONE;
      DONE:    w_state_next = (r_err || !HAS_GAP) ? IDLE : GAP;
      GAP:     if (r_gap_cnt == GAP_LAST) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // MISO is sampled on the edges that raise SCLK; only the newest word is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_hi  <= 1'b0;
      r_bit_cnt  <= '0;
      r_gap_cnt  <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_rsp_data <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_tx      <= {req_cmd, req_index,
                        is_write_cmd(req_cmd) ? req_wdata : WORD_W'(SPI_DUMMY_BYTE)};
          r_bit_cnt <= '0;
          r_sclk_hi <= 1'b0;
          r_err     <= !w_cmd_ok;
          if (!w_cmd_ok) r_rsp_data <= '0;
        end
        SETUP: if (w_tick) begin
          r_sclk_hi <= 1'b1;
          r_rx      <= {r_rx[WORD_W-2:0], spi_miso};
        end
        SHIFT: if (w_tick) begin
          if (r_sclk_hi) begin
            r_sclk_hi <= 1'b0;
            r_tx      <= {r_tx[NBITS-2:0], 1'b0};
          end else if (w_last_bit) begin
            r_rsp_data <= r_rx;
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
            r_sclk_hi <= 1'b1;
            r_rx      <= {r_rx[WORD_W-2:0], spi_miso};
          end
        end
        DONE:    r_gap_cnt <= '0;
        GAP:     r_gap_cnt <= r_gap_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready = (r_state == IDLE);
    busy      = (r_state != IDLE);
    spi_cs_n  = !w_div_en;
    spi_sclk  = (r_state == SHIFT) && r_sclk_hi;
    spi_mosi  = w_div_en ? r_tx[NBITS-1] : 1'b0;
    rsp_valid = (r_state == DONE);
    rsp_data  = r_rsp_data;
`ifdef SPI_CMD_CHECK_EN
    rsp_err   = (r_state == DONE) && r_err;
`else
    rsp_err   = 1'b0;
`endif
  end

endmodule

// File: doc/spi_cmd_master.md
# spi_cmd_master

Host-side SPI initiator for the safety-board command protocol. Accepts one command request (command byte, index, write data) over a valid/ready handshake and serialises it as a single three-word, chip-select-framed SPI mode-0 transaction. It returns the slave's third-word reply as response data. Sits between the supervisory controller logic and the SPI pins that drive the safety-board command decoder.

## Interface
- CLK_DIV, 4: system clocks per SCLK half-period; legal range ≥1.
- CS_GAP, 8: minimum system clocks cs_n stays high between frames; legal range ≥1.
- WORD_W, `SPI_WORD_LENGTH (8): bits per SPI word.
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_cmd  input  WORD_W  command byte (spi_cmd_t encoding).
- req_index  input  WORD_W  contactor/feedback index; sent as word 1.
- req_wdata  input  WORD_W  write payload; sent as word 2 for write commands only.
- rsp_valid  output  1  one-cycle pulse at end of request.
- rsp_data  output  WORD_W  MISO content of word 2; held until next frame starts.
- rsp_err  output  1  qualified by rsp_valid; illegal command rejected.
- busy  output  1  high from accept until gap ends.
- spi_sclk  output  1  SPI clock, idle low.
- spi_cs_n  output  1  chip select, active low.
- spi_mosi  output  1  master out.
- spi_miso  input  1  slave in; synchronous to spi_sclk, sampled directly (no synchroniser).

## Operation
- Reset values: req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, spi_sclk=0, spi_cs_n=1, spi_mosi=0.
- Handshake: request accepted on a clock edge with req_valid && req_ready. Inputs are captured at that edge. The requester holds them stable while req_valid && !req_ready. req_ready=0 from accept until the gap completes.
- Frame: word0=req_cmd, word1=req_index, word2=req_wdata if req_cmd[7]=1 (write), else 8'h00. Each word is sent MSB first; 3×WORD_W bits total.
- Mode 0: MOSI changes only while SCLK is low. MISO is sampled on the system edge that drives SCLK high.
- FSM states:
  - IDLE → SETUP on accept.
  - SETUP (cs_n low, sclk low, bit 0 on MOSI, CLK_DIV cycles) → SHIFT.
  - SHIFT (per bit: high half then low half, CLK_DIV cycles each; next bit placed at the high→low transition) → after the last low half, DONE.
  - DONE (cs_n high, rsp_valid pulse, 1 cycle) → GAP.
  - GAP (CS_GAP−1 further cycles) → IDLE.
- rsp_data is updated in DONE with the last WORD_W sampled bits. MISO from words 0–1 is discarded.
- No response backpressure: rsp_valid is a single-cycle pulse, never stalled.
- Reset mid-frame: cs_n=1 and sclk=0 immediately (asynchronously). The frame is aborted with no rsp_valid. The block resumes in IDLE.
- Counter widths: the half-period counter is $clog2(CLK_DIV+1) bits and the bit counter is $clog2(3*WORD_W+1) bits. Neither wraps; both reload per state.

## Timing
- Accept at edge N: cs_n falls at edge N+1.
- cs_n low for exactly (1+2×3×WORD_W)×CLK_DIV cycles, which is 49×CLK_DIV for 8-bit words.
- rsp_valid is high in the first cycle cs_n is high again.
- Next accept is possible at the earliest CS_GAP cycles after cs_n rises, so cs_n high time between frames is ≥CS_GAP+1.
- 3×WORD_W SCLK rising edges per frame; SCLK period 2×CLK_DIV.

## Configuration
- SPI_CMD_CHECK_EN defined:
  - req_cmd not in the eight spi_cmd_t codes is still accepted, but no frame is generated and cs_n stays high.
  - At the next edge, rsp_valid=1, rsp_err=1 and rsp_data=0. GAP is then skipped and the block returns to IDLE.
- SPI_CMD_CHECK_EN undefined: any byte is transmitted and rsp_err is tied 0.

## Structure
- The shared SPI package gains:
  - spi_master_state_t enum (IDLE, SETUP, SHIFT, DONE, GAP);
  - localparam SPI_FRAME_WORDS=3 and SPI_DUMMY_BYTE=8'h00;
  - functions is_write_cmd (bit 7) and is_valid_cmd (matches a spi_cmd_t member).
- One sub-module, spi_sclk_div: half-period tick generator, cleared at frame start.

## Test plan
- Write, CLK_DIV=2: cmd 0x81, idx 0x03, wdata 0x02 → MOSI carries 0x81,0x03,0x02; 24 SCLK rises; cs_n low 98 cycles; one rsp_valid with rsp_err=0.
- Read: cmd 0x02, idx 0x05, slave model returns 0x00,0x00,0x03 → word2 MOSI=0x00; rsp_data=0x03 and held after rsp_valid.
- req_valid held high for two requests, CS_GAP=4 → req_ready low throughout frame and gap; cs_n high ≥5 cycles between frames.
- rst_n pulled low during bit 10 → cs_n=1 and sclk=0 without a clock edge; no rsp_valid; next request completes normally.
- SPI_CMD_CHECK_EN defined, cmd 0x55 → rsp_valid and rsp_err one cycle after accept, cs_n never low. Undefined → 0x55 transmitted, rsp_err=0.
- CLK_DIV=1 → SCLK period 2 cycles, cs_n low 49 cycles, MISO sampled correctly.
